// File: rtl/bus_xcvr_pkg.sv
// bus_xcvr_pkg: shared state encodings, direction constants and counter sizing for the bus transceiver
package bus_xcvr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRV_AB = 2'd1,
        DRV_BA = 2'd2,
        TURN   = 2'd3
    } state_e;

    localparam logic DIR_AB = 1'b1;
    localparam logic DIR_BA = 1'b0;

    function automatic int cnt_w(input int tc);
        return (tc > 0) ? $clog2(tc + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_turn_fsm.sv
// bus_turn_fsm: direction FSM with dead-cycle turnaround counter and enable/busy decode
module bus_turn_fsm
    import bus_xcvr_pkg::*;
#(
    parameter int TURN_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic oe_i,
    input  logic dir_i,
    output logic a_oe_o,
    output logic b_oe_o,
    output logic busy_o
);

    localparam int CW = cnt_w(TURN_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    state_e          state_q, state_d;
    logic            tgt_q, tgt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    state_e          drv_req;
    logic            cur_dir;

    assign drv_req = (dir_i == DIR_AB) ? DRV_AB : DRV_BA;
    assign cur_dir = (state_q == DRV_AB) ? DIR_AB : DIR_BA;

    // State, pending target direction and dead-cycle counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tgt_q   <= DIR_BA;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: OE always wins; a reversal detours through TURN unless no dead cycles are configured
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = oe_i ? drv_req : IDLE;
            DRV_AB, DRV_BA: begin
                if (!oe_i) begin
                    state_d = IDLE;
                end else if (dir_i != cur_dir) begin
                    state_d = (TURN_CYCLES == 0) ? drv_req : TURN;
                    tgt_d   = dir_i;
                    cnt_d   = RELOAD;
                end
            end
            TURN: begin
                if (!oe_i) begin
                    state_d = IDLE;
                end else if (dir_i != tgt_q) begin
                    tgt_d = dir_i;
                    cnt_d = RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = drv_req;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign b_oe_o = (state_q == DRV_AB);
    assign a_oe_o = (state_q == DRV_BA);
    assign busy_o = (state_q == TURN);

endmodule

// File: rtl/bus_xcvr_reg.sv
// bus_xcvr_reg: registered bidirectional bus transceiver with per-direction holding registers and safe turnaround
module bus_xcvr_reg
    import bus_xcvr_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             oe_i,
    input  logic             dir_i,
    input  logic             sab_i,
    input  logic             sba_i,
    input  logic             lab_i,
    input  logic             lba_i,
    input  logic [WIDTH-1:0] a_in_i,
    output logic [WIDTH-1:0] a_out_o,
    output logic             a_oe_o,
    input  logic [WIDTH-1:0] b_in_i,
    output logic [WIDTH-1:0] b_out_o,
    output logic             b_oe_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;

    // Holding registers load independently of enable, direction and FSM state
    always_comb begin
        reg_a_d = lab_i ? a_in_i : reg_a_q;
        reg_b_d = lba_i ? b_in_i : reg_b_q;
    end

    // Holding register storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
        end else begin
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
        end
    end

    // Zero-latency output muxes, forced low while reset is held
    always_comb begin
        b_out_o = rst_i ? '0 : (sab_i ? reg_a_q : a_in_i);
        a_out_o = rst_i ? '0 : (sba_i ? reg_b_q : b_in_i);
    end

    bus_turn_fsm #(
        .TURN_CYCLES(TURN_CYCLES)
    ) u_fsm (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .oe_i  (oe_i),
        .dir_i (dir_i),
        .a_oe_o(a_oe_o),
        .b_oe_o(b_oe_o),
        .busy_o(busy_o)
    );

endmodule

// File: tb/tb_bus_xcvr_reg.sv
// tb_bus_xcvr_reg: directed checks of the transceiver with two dead cycles (8 bit) and an immediate-switch 16-bit build
module tb_bus_xcvr_reg;

    logic        clk = 1'b0;
    logic        rst, oe, dir, sab, sba, lab, lba;
    logic [7:0]  a_in, b_in, a_out, b_out;
    logic        a_oe, b_oe, busy;
    logic [15:0] a_in16, b_in16, a_out16, b_out16;
    logic        a_oe16, b_oe16, busy16;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    bus_xcvr_reg #(.WIDTH(8), .TURN_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst), .oe_i(oe), .dir_i(dir), .sab_i(sab), .sba_i(sba),
        .lab_i(lab), .lba_i(lba), .a_in_i(a_in), .a_out_o(a_out), .a_oe_o(a_oe),
        .b_in_i(b_in), .b_out_o(b_out), .b_oe_o(b_oe), .busy_o(busy)
    );

    bus_xcvr_reg #(.WIDTH(16), .TURN_CYCLES(0)) dut16 (
        .clk_i(clk), .rst_i(rst), .oe_i(oe), .dir_i(dir), .sab_i(sab), .sba_i(sba),
        .lab_i(lab), .lba_i(lba), .a_in_i(a_in16), .a_out_o(a_out16), .a_oe_o(a_oe16),
        .b_in_i(b_in16), .b_out_o(b_out16), .b_oe_o(b_oe16), .busy_o(busy16)
    );

    // Both sides must never be enabled together in either build
    always @(negedge clk) begin
        checks++;
        if ((a_oe && b_oe) || (a_oe16 && b_oe16)) begin
            errors++;
            $display("FAIL overlap t=%0t a_oe=%b b_oe=%b a_oe16=%b b_oe16=%b required no overlap", $time, a_oe, b_oe, a_oe16, b_oe16);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; oe = 1'($urandom); dir = 1'($urandom); sab = 1'($urandom); sba = 1'($urandom);
        lab = 1'b1; lba = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom);
        a_in16 = 16'($urandom); b_in16 = 16'($urandom);
        #2;
        checks++;
        if ({a_oe, b_oe, busy, a_out, b_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got oe=%b%b busy=%b a=%h b=%h required all zero", a_oe, b_oe, busy, a_out, b_out);
        end
        tick();
        tick();
        oe = 1'b0; sab = 1'b1; sba = 1'b1; lab = 1'b0; lba = 1'b0; a_in = 8'hFF; b_in = 8'hFF;
        a_in16 = 16'hFFFF; b_in16 = 16'hFFFF;
        rst = 1'b0;
        #1;
        checks++;
        if ({a_out, b_out} !== 16'h0000 || {a_out16, b_out16} !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs got a=%h b=%h a16=%h b16=%h required zero", a_out, b_out, a_out16, b_out16);
        end
        tick();
        tick();
        checks++;
        if ({a_oe, b_oe, busy, a_oe16, b_oe16, busy16} !== 6'b0) begin
            errors++;
            $display("FAIL idle_hold got %b%b%b %b%b%b required 000 000", a_oe, b_oe, busy, a_oe16, b_oe16, busy16);
        end
    endtask

    task automatic test_drive_ab();
        oe = 1'b1; dir = 1'b1; sab = 1'b0; a_in = 8'h5A; a_in16 = 16'hA55A;
        #1;
        checks++;
        if (b_oe !== 1'b0 || b_out !== 8'h5A || b_out16 !== 16'hA55A) begin
            errors++;
            $display("FAIL ab_pre got b_oe=%b b=%h b16=%h required 0 5a a55a", b_oe, b_out, b_out16);
        end
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b010 || b_out !== 8'h5A) begin
            errors++;
            $display("FAIL ab_drive got a_oe=%b b_oe=%b busy=%b b=%h required 0 1 0 5a", a_oe, b_oe, busy, b_out);
        end
        checks++;
        if ({a_oe16, b_oe16} !== 2'b01) begin
            errors++;
            $display("FAIL ab_drive16 got a_oe=%b b_oe=%b required 0 1", a_oe16, b_oe16);
        end
    endtask

    task automatic test_turn();
        dir = 1'b0;
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b001) begin
            errors++;
            $display("FAIL turn_e1 got %b%b%b required 001", a_oe, b_oe, busy);
        end
        checks++;
        if ({a_oe16, b_oe16, busy16} !== 3'b100) begin
            errors++;
            $display("FAIL turn0_e1 got %b%b%b required 100", a_oe16, b_oe16, busy16);
        end
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b001) begin
            errors++;
            $display("FAIL turn_e2 got %b%b%b required 001", a_oe, b_oe, busy);
        end
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b100) begin
            errors++;
            $display("FAIL turn_e3 got %b%b%b required 100", a_oe, b_oe, busy);
        end
    endtask

    task automatic test_hold();
        dir = 1'b1; lab = 1'b1; sab = 1'b1; a_in = 8'hC3;
        #1;
        checks++;
        if (b_out !== 8'h00) begin
            errors++;
            $display("FAIL hold_old got %h required 00", b_out);
        end
        tick();
        lab = 1'b0; a_in = 8'h00;
        #1;
        checks++;
        if (b_out !== 8'hC3) begin
            errors++;
            $display("FAIL hold_a got %h required c3", b_out);
        end
        tick();
        tick();
        checks++;
        if (b_oe !== 1'b1 || b_out !== 8'hC3) begin
            errors++;
            $display("FAIL hold_drive got b_oe=%b b=%h required 1 c3", b_oe, b_out);
        end
        lba = 1'b1; sba = 1'b1; b_in = 8'h3C;
        #1;
        checks++;
        if (a_out !== 8'h00) begin
            errors++;
            $display("FAIL hold_b_old got %h required 00", a_out);
        end
        tick();
        lba = 1'b0; b_in = 8'h99;
        #1;
        checks++;
        if (a_out !== 8'h3C) begin
            errors++;
            $display("FAIL hold_b got %h required 3c", a_out);
        end
    endtask

    task automatic test_turn_abort();
        dir = 1'b0;
        tick();
        tick();
        dir = 1'b1;
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b001) begin
            errors++;
            $display("FAIL retarget_e3 got %b%b%b required 001", a_oe, b_oe, busy);
        end
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b001) begin
            errors++;
            $display("FAIL retarget_e4 got %b%b%b required 001", a_oe, b_oe, busy);
        end
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b010) begin
            errors++;
            $display("FAIL retarget_end got %b%b%b required 010", a_oe, b_oe, busy);
        end
        dir = 1'b0;
        tick();
        oe = 1'b0;
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL abort got %b%b%b required 000", a_oe, b_oe, busy);
        end
    endtask

    task automatic test_rst_mid();
        oe = 1'b1; dir = 1'b0;
        tick();
        checks++;
        if (a_oe !== 1'b1) begin
            errors++;
            $display("FAIL drv_ba got a_oe=%b required 1", a_oe);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (a_oe !== 1'b0 || a_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_async got a_oe=%b a=%h required 0 00", a_oe, a_out);
        end
        #1;
        rst = 1'b0; dir = 1'b1; sab = 1'b1;
        tick();
        checks++;
        if ({a_oe, b_oe, busy} !== 3'b010 || b_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_resume got %b%b%b b=%h required 010 00", a_oe, b_oe, busy, b_out);
        end
    endtask

    initial begin
        test_reset();
        test_drive_ab();
        test_turn();
        test_hold();
        test_turn_abort();
        test_rst_mid();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
